// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner control PHYs: arbiter FSM states, channel roles
// and the index-width helper used for grant ports.
package tuner_phy_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        TUNE,
        SYNC,
        COMMIT
    } tuner_phy_ctrl_arb_mc_state_e;

    localparam int CH_SEARCH = 0;
    localparam int CH_LOCK   = 1;

    // A single channel still needs a one-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tuner_rr_arb.sv
// Round-robin arbiter: the search starts at the channel after the last grant.
// The pointer moves only when a grant is actually taken (advance & any).
module tuner_rr_arb
    import tuner_phy_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      advance,
    output logic [NUM_CH-1:0]         grant_oh,
    output logic [idx_w(NUM_CH)-1:0]  grant_idx,
    output logic                      any
);

    localparam int IW = idx_w(NUM_CH);

    logic [IW-1:0] ptr;
    logic [IW:0]   cand;

    // Walk from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(NUM_CH)) cand = cand - (IW + 1)'(NUM_CH);
            if (req[cand[IW-1:0]]) begin
                grant_idx = cand[IW-1:0];
                any       = 1'b1;
            end
        end
        grant_oh = any ? (NUM_CH'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/tuner_ctrl_arb_mc_phy.sv
// Arbitrates several tuner controllers onto one ring-tuner AFE port: fire the
// granted tune code, wait N power-detect edges, then commit the (tune, pwr) pair.
module tuner_ctrl_arb_mc_phy
    import tuner_phy_pkg::*;
#(
    parameter int DAC_WIDTH      = 8,
    parameter int ADC_WIDTH      = 8,
    parameter int NUM_CH         = 2,
    parameter int SYNC_CNT_WIDTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ctrl_refresh,
    input  logic [NUM_CH-1:0]             i_ctrl_active,
    input  logic [SYNC_CNT_WIDTH-1:0]     i_sync_cycle,
    input  logic [NUM_CH-1:0]             i_ring_tune_val,
    output logic [NUM_CH-1:0]             o_ring_tune_rdy,
    input  logic [NUM_CH*DAC_WIDTH-1:0]   i_ring_tune,
    output logic [NUM_CH-1:0]             o_commit_val,
    input  logic [NUM_CH-1:0]             i_commit_rdy,
    output logic [ADC_WIDTH-1:0]          o_pwr_commit,
    output logic [DAC_WIDTH-1:0]          o_ring_tune_commit,
    output logic [idx_w(NUM_CH)-1:0]      o_grant_ch,
    output logic                          o_busy,
    input  logic                          i_pwr_detect_update,
    input  logic [ADC_WIDTH-1:0]          i_pwr_detect_data,
    output logic                          o_pwr_detect_active,
    output logic                          o_pwr_detect_refresh,
    output logic [DAC_WIDTH-1:0]          o_dig_afe_ring_tune,
    output logic                          o_afe_ring_tune_val,
    input  logic                          i_afe_ring_tune_rdy,
    output logic [2:0]                    o_dbg_state
);

    localparam int GW = idx_w(NUM_CH);

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high; valid never depends on ready, and ready is only raised in TUNE.
    tuner_phy_ctrl_arb_mc_state_e state, state_n;

    logic [GW-1:0]             grant;
    logic [NUM_CH-1:0]         grant_oh;
    logic [DAC_WIDTH-1:0]      tracked;
    logic [SYNC_CNT_WIDTH-1:0] sync_n;
    logic [SYNC_CNT_WIDTH-1:0] sync_cnt;
    logic                      upd_q;
    logic [ADC_WIDTH-1:0]      pwr_commit;
    logic [DAC_WIDTH-1:0]      tune_commit;

    logic [NUM_CH-1:0]         arb_oh;
    logic [GW-1:0]             arb_idx;
    logic                      arb_any;
    logic [DAC_WIDTH-1:0]      tune_g;
    logic                      act_g, val_g, crdy_g, fire, upd_edge, last_edge;

    tuner_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (i_ctrl_refresh),
        .req       (i_ring_tune_val & i_ctrl_active),
        .advance   (state == IDLE),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_comb begin
        tune_g = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_oh[i]) tune_g = i_ring_tune[i*DAC_WIDTH +: DAC_WIDTH];
        end
    end

    assign act_g     = |(i_ctrl_active & grant_oh);
    assign val_g     = |(i_ring_tune_val & grant_oh);
    assign crdy_g    = |(i_commit_rdy & grant_oh);
    assign fire      = o_afe_ring_tune_val & i_afe_ring_tune_rdy;
    assign upd_edge  = i_pwr_detect_update & ~upd_q;
    assign last_edge = upd_edge && ((sync_cnt + 1'b1) == sync_n);

    always_comb begin
        state_n = state;
        case (state)
            INIT:    state_n = IDLE;
            IDLE:    if (arb_any) state_n = TUNE;
            TUNE:    if (!act_g) state_n = IDLE;
                     else if (fire) state_n = SYNC;
            SYNC:    if (!act_g) state_n = IDLE;
                     else if (last_edge) state_n = COMMIT;
            COMMIT:  if (!act_g || crdy_g) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= INIT;
        end else if (i_ctrl_refresh) begin
            state <= INIT;
        end else begin
            state <= state_n;
        end
    end

    // Refresh clears everything, discarding any fire or commit in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant       <= '0;
            grant_oh    <= '0;
            tracked     <= '0;
            sync_n      <= '0;
            sync_cnt    <= '0;
            upd_q       <= 1'b0;
            pwr_commit  <= '0;
            tune_commit <= '0;
        end else if (i_ctrl_refresh) begin
            grant       <= '0;
            grant_oh    <= '0;
            tracked     <= '0;
            sync_n      <= '0;
            sync_cnt    <= '0;
            upd_q       <= 1'b0;
            pwr_commit  <= '0;
            tune_commit <= '0;
        end else begin
            upd_q <= i_pwr_detect_update;
            if (state == IDLE && arb_any) begin
                grant    <= arb_idx;
                grant_oh <= arb_oh;
            end
            if (fire) begin
                tracked  <= tune_g;
                sync_n   <= (i_sync_cycle == '0) ? SYNC_CNT_WIDTH'(1) : i_sync_cycle;
                sync_cnt <= '0;
            end
            if (state == SYNC && upd_edge) begin
                sync_cnt    <= sync_cnt + 1'b1;
                pwr_commit  <= i_pwr_detect_data;
                tune_commit <= tracked;
            end
        end
    end

    assign o_afe_ring_tune_val  = (state == TUNE) && val_g;
    assign o_ring_tune_rdy      = ((state == TUNE) && i_afe_ring_tune_rdy) ? grant_oh : '0;
    assign o_dig_afe_ring_tune  = fire ? tune_g : tracked;
    assign o_commit_val         = (state == COMMIT) ? grant_oh : '0;
    assign o_pwr_commit         = pwr_commit;
    assign o_ring_tune_commit   = tune_commit;
    assign o_grant_ch           = grant;
    assign o_busy               = (state == TUNE) || (state == SYNC) || (state == COMMIT);
    assign o_pwr_detect_active  = |i_ctrl_active;
    assign o_pwr_detect_refresh = i_ctrl_refresh;
    assign o_dbg_state          = state;

endmodule

// File: tb/tb_tuner_ctrl_arb_mc_phy.sv
// Bench for tuner_ctrl_arb_mc_phy: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_tuner_ctrl_arb_mc_phy;
    import tuner_phy_pkg::*;

    localparam int NUM_CH = 2;
    localparam int DW     = 8;
    localparam int AW     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              refresh = 1'b0;
    logic [NUM_CH-1:0] active = '0;
    logic [3:0]        sync_cycle = '0;
    logic [NUM_CH-1:0] tune_val = '0;
    logic [NUM_CH-1:0] tune_rdy;
    logic [DW-1:0]     tune0 = '0, tune1 = '0;
    logic [NUM_CH-1:0] commit_val;
    logic [NUM_CH-1:0] commit_rdy = '0;
    logic [AW-1:0]     pwr_commit;
    logic [DW-1:0]     tune_commit;
    logic [0:0]        grant_ch;
    logic              busy;
    logic              upd = 1'b0;
    logic [AW-1:0]     upd_data = '0;
    logic              det_active, det_refresh;
    logic [DW-1:0]     afe_code;
    logic              afe_val;
    logic              afe_rdy = 1'b0;
    logic [2:0]        dbg_state;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    tuner_ctrl_arb_mc_phy #(
        .DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_CH(NUM_CH), .SYNC_CNT_WIDTH(4)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_ctrl_refresh      (refresh),
        .i_ctrl_active       (active),
        .i_sync_cycle        (sync_cycle),
        .i_ring_tune_val     (tune_val),
        .o_ring_tune_rdy     (tune_rdy),
        .i_ring_tune         ({tune1, tune0}),
        .o_commit_val        (commit_val),
        .i_commit_rdy        (commit_rdy),
        .o_pwr_commit        (pwr_commit),
        .o_ring_tune_commit  (tune_commit),
        .o_grant_ch          (grant_ch),
        .o_busy              (busy),
        .i_pwr_detect_update (upd),
        .i_pwr_detect_data   (upd_data),
        .o_pwr_detect_active (det_active),
        .o_pwr_detect_refresh(det_refresh),
        .o_dig_afe_ring_tune (afe_code),
        .o_afe_ring_tune_val (afe_val),
        .i_afe_ring_tune_rdy (afe_rdy),
        .o_dbg_state         (dbg_state)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: phase 0 init, 1 idle, 2 awaiting fire, 3 collecting
    // detect edges, 4 offering commit.
    int ph, mg, mptr, mcode, mneed, mpwr, mtune, c;
    bit prev_upd, m_edge, found;

    function automatic int code_of(input int ch);
        return (ch == 0) ? int'(tune0) : int'(tune1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || refresh) begin
            ph = 0; mg = 0; mptr = 0; mcode = 0; mneed = 0;
            mpwr = 0; mtune = 0; prev_upd = 0;
        end else begin
            m_edge   = upd && !prev_upd;
            prev_upd = upd;
            case (ph)
                0: ph = 1;
                1: begin
                    found = 0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        c = (mptr + k) % NUM_CH;
                        if (!found && tune_val[c] && active[c]) begin
                            found = 1;
                            mg = c;
                        end
                    end
                    if (found) begin
                        mptr = (mg + 1) % NUM_CH;
                        ph = 2;
                    end
                end
                2: if (!active[mg]) ph = 1;
                   else if (tune_val[mg] && afe_rdy) begin
                       mcode = code_of(mg);
                       mneed = (sync_cycle == 0) ? 1 : int'(sync_cycle);
                       ph = 3;
                   end
                3: if (!active[mg]) ph = 1;
                   else if (m_edge) begin
                       mpwr = int'(upd_data);
                       mtune = mcode;
                       mneed--;
                       if (mneed == 0) ph = 4;
                   end
                4: if (!active[mg] || commit_rdy[mg]) ph = 1;
                default: ph = 0;
            endcase
        end
    end

    int e_val;
    always @(negedge clk) begin
        if (chk_on) begin
            e_val = (ph == 2 && tune_val[mg]) ? 1 : 0;
            chk("state", int'(dbg_state), ph);
            chk("busy", int'(busy), (ph >= 2) ? 1 : 0);
            chk("grant", int'(grant_ch), mg);
            chk("commit_val", int'(commit_val), (ph == 4) ? (1 << mg) : 0);
            chk("tune_rdy", int'(tune_rdy), (ph == 2 && afe_rdy) ? (1 << mg) : 0);
            chk("afe_val", int'(afe_val), e_val);
            chk("afe_code", int'(afe_code), (e_val == 1 && afe_rdy) ? code_of(mg) : mcode);
            chk("pwr_commit", int'(pwr_commit), mpwr);
            chk("tune_commit", int'(tune_commit), mtune);
            chk("det_active", int'(det_active), (active != 0) ? 1 : 0);
            chk("det_refresh", int'(det_refresh), int'(refresh));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int d);
        upd = 1'b1;
        upd_data = AW'(d);
        cyc();
        upd = 1'b0;
        cyc();
    endtask

    task automatic start_txn(input int ch, input int n);
        sync_cycle = 4'(n);
        tune_val = NUM_CH'(1 << ch);
        cyc();
        cyc();
        tune_val = '0;
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    int prev_st;

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_on = 1;
        cyc(3);
        chk("reset_state", int'(dbg_state), int'(INIT));
        chk("reset_code", int'(afe_code), 0);
        rst_n = 1'b1;
        cyc();
        chk("init_to_idle", int'(dbg_state), int'(IDLE));

        // Single search request, N=4, four detect edges.
        afe_rdy = 1'b1;
        active = 2'b01;
        tune0 = 8'hA5;
        start_txn(CH_SEARCH, 4);
        chk("fire_to_sync", int'(dbg_state), int'(SYNC));
        pulse(10); pulse(20); pulse(30); pulse(40);
        chk("s1_commit_val", int'(commit_val), 1);
        chk("s1_pwr", int'(pwr_commit), 40);
        chk("s1_code", int'(tune_commit), 8'hA5);
        commit_rdy = 2'b01;
        cyc();
        commit_rdy = '0;
        chk("s1_done", int'(busy), 0);

        // Both channels request continuously: grants alternate.
        refresh = 1'b1; cyc(); refresh = 1'b0; cyc();
        active = 2'b11; tune_val = 2'b11; sync_cycle = 4'd1; commit_rdy = 2'b11;
        tune0 = 8'h11; tune1 = 8'h22;
        exp_q = '{4'd0, 4'd1, 4'd0, 4'd1};
        prev_st = int'(dbg_state);
        for (int t = 0; t < 100 && got_q.size() < 4; t++) begin
            upd = ~upd;
            cyc();
            if (int'(dbg_state) == int'(TUNE) && prev_st != int'(TUNE)) got_q.push_back(4'(grant_ch));
            prev_st = int'(dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            chk("alt_grant", (i < got_q.size()) ? int'(got_q[i]) : 15, int'(exp_q[i]));
        end
        tune_val = '0; commit_rdy = '0; upd = 1'b0;
        refresh = 1'b1; cyc(); refresh = 1'b0; cyc();

        // Update held high five cycles counts once; N=2.
        active = 2'b01;
        tune0 = 8'h5A;
        start_txn(CH_SEARCH, 2);
        upd = 1'b1; upd_data = 8'h55;
        cyc(5);
        chk("held_still_sync", int'(dbg_state), int'(SYNC));
        upd = 1'b0; cyc();
        upd = 1'b1; upd_data = 8'h66; cyc(); upd = 1'b0;
        chk("held_commit", int'(dbg_state), int'(COMMIT));
        chk("held_pwr", int'(pwr_commit), 8'h66);
        commit_rdy = 2'b01; cyc(); commit_rdy = '0;

        // Sync count of zero behaves as one.
        start_txn(CH_SEARCH, 0);
        upd = 1'b1; upd_data = 8'h77; cyc(); upd = 1'b0;
        chk("n0_commit", int'(dbg_state), int'(COMMIT));
        commit_rdy = 2'b01; cyc(); commit_rdy = '0;

        // Lock channel drops active mid-SYNC: abort, code retained.
        active = 2'b10;
        tune1 = 8'h3C;
        start_txn(CH_LOCK, 3);
        pulse(8'h90);
        active = 2'b00;
        cyc();
        chk("abort_idle", int'(dbg_state), int'(IDLE));
        chk("abort_noval", int'(commit_val), 0);
        chk("abort_code", int'(afe_code), 8'h3C);
        cyc();

        // Asynchronous reset mid-SYNC.
        active = 2'b01;
        tune0 = 8'hC3;
        start_txn(CH_SEARCH, 4);
        pulse(8'h12);
        rst_n = 1'b0;
        #1;
        chk("rst_state", int'(dbg_state), int'(INIT));
        chk("rst_code", int'(afe_code), 0);
        chk("rst_pwr", int'(pwr_commit), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_idle", int'(dbg_state), int'(IDLE));

        // Refresh coinciding with commit accept: refresh wins.
        start_txn(CH_SEARCH, 1);
        upd = 1'b1; upd_data = 8'h44; cyc(); upd = 1'b0;
        chk("pre_refresh_commit", int'(commit_val), 1);
        commit_rdy = 2'b01; refresh = 1'b1;
        cyc();
        chk("refresh_state", int'(dbg_state), int'(INIT));
        chk("refresh_pwr", int'(pwr_commit), 0);
        chk("refresh_code", int'(afe_code), 0);
        commit_rdy = '0; refresh = 1'b0;
        cyc();
        chk("refresh_idle", int'(dbg_state), int'(IDLE));
        cyc(2);

        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
